// File: rtl/ksa23_limb_seq.sv
// Serial multi-limb adder: streams 23-bit limb pairs LS-first through a Kogge-Stone core, chaining carry; 1-cycle latency.
// Optional KSA_LIMB_CIN_EN adds in_cin to seed the first-limb carry; in_ready drops while an output is held unaccepted.

module UBPriKSA_22_0 (
  input  logic [22:0] x_i,
  input  logic [22:0] y_i,
  input  logic        cin_i,
  output logic [22:0] sum_o,
  output logic        cout_o
);

  // Carry-in is folded into bit 0's generate so the prefix tree yields carries directly.
  function automatic logic [23:0] ks_add(input logic [22:0] a, input logic [22:0] b,
                                         input logic c0);
    logic [22:0] h;
    logic [22:0] g;
    logic [22:0] p;
    logic [22:0] gn;
    logic [22:0] pn;
    int          d;
    h    = a ^ b;
    g    = a & b;
    p    = h;
    g[0] = g[0] | (h[0] & c0);
    for (int s = 0; s < 5; s++) begin
      d  = 1 << s;
      gn = g;
      pn = p;
      for (int i = 0; i < 23 - d; i++) begin
        gn[i + d] = g[i + d] | (p[i + d] & g[i]);
        pn[i + d] = p[i + d] & p[i];
      end
      g = gn;
      p = pn;
    end
    return {g[22], h ^ {g[21:0], c0}};
  endfunction

  assign {cout_o, sum_o} = ks_add(x_i, y_i, cin_i);

endmodule

module ksa23_limb_seq #(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [22:0]      in_x,
  input  logic [22:0]      in_y,
  input  logic             in_first,
  input  logic             in_last,
`ifdef KSA_LIMB_CIN_EN
  input  logic             in_cin,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [22:0]      out_sum,
  output logic             out_last,
  output logic             out_cout,
  output logic [IDX_W-1:0] out_idx
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               out_valid_q, out_valid_d;
  logic [22:0]        out_sum_q, out_sum_d;
  logic               out_last_q, out_last_d;
  logic               out_cout_q, out_cout_d;
  logic [IDX_W-1:0]   out_idx_q, out_idx_d;

  logic               accept;
  logic               is_first;
  logic               first_cin;
  logic               cin_sel;
  logic [IDX_W-1:0]   cur_idx;
  logic [22:0]        core_sum;
  logic               core_cout;

`ifdef KSA_LIMB_CIN_EN
  assign first_cin = in_cin;
`else
  assign first_cin = 1'b0;
`endif

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  // An explicit first limb aborts any open operation; a stray non-first limb in IDLE starts one.
  assign is_first = in_first || (state_q == IDLE);
  assign cin_sel  = is_first ? first_cin : carry_q;
  assign cur_idx  = is_first ? '0 : idx_q;

  UBPriKSA_22_0 u_core (
    .x_i    (in_x),
    .y_i    (in_y),
    .cin_i  (cin_sel),
    .sum_o  (core_sum),
    .cout_o (core_cout)
  );

  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_last_d  = out_last_q;
    out_cout_d  = out_cout_q;
    out_idx_d   = out_idx_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_sum_d   = core_sum;
      out_last_d  = in_last;
      out_cout_d  = in_last ? core_cout : 1'b0;
      out_idx_d   = cur_idx;
      if (in_last) begin
        state_d = IDLE;
        carry_d = 1'b0;
        idx_d   = '0;
      end else begin
        state_d = RUN;
        carry_d = core_cout;
        idx_d   = cur_idx + IDX_W'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      out_cout_q  <= out_cout_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign out_cout  = out_cout_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_ksa23_limb_seq.sv
// Randomized scoreboard bench for ksa23_limb_seq; reference is a wide-integer add per operation.
module tb_ksa23_limb_seq;

  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [22:0]      in_x = '0;
  logic [22:0]      in_y = '0;
  logic             in_first = 1'b0;
  logic             in_last = 1'b0;
  logic             in_cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [22:0]      out_sum;
  logic             out_last;
  logic             out_cout;
  logic [IDX_W-1:0] out_idx;

  ksa23_limb_seq #(.IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_first  (in_first),
    .in_last   (in_last),
`ifdef KSA_LIMB_CIN_EN
    .in_cin    (in_cin),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_cout  (out_cout),
    .out_idx   (out_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [22:0]      sum;
    logic             last;
    logic             cout;
    logic [IDX_W-1:0] idx;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        stall_req = 1'b0;
  logic        rand_bp = 1'b0;
  logic        prev_open = 1'b0;
  logic [22:0] opx[8];
  logic [22:0] opy[8];
  int          acc_c[8];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: chooses out_ready for the coming edge, then checks any limb that will pop on it.
  always @(negedge clk) begin
    exp_t e;
    out_ready = stall_req ? 1'b0 : (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got sum=%h last=%b idx=%0d, required no output",
                 out_sum, out_last, out_idx);
      end else begin
        e = sb.pop_front();
        if (out_sum !== e.sum || out_last !== e.last || out_cout !== e.cout || out_idx !== e.idx) begin
          errors++;
          $display("FAIL limb: got sum=%h last=%b cout=%b idx=%0d, required sum=%h last=%b cout=%b idx=%0d",
                   out_sum, out_last, out_cout, out_idx, e.sum, e.last, e.cout, e.idx);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_limb(input logic [22:0] x, input logic [22:0] y, input logic first,
                           input logic last, input logic cin, input exp_t e, output int acc);
    bit done = 0;
    acc = -1;
    if (rand_bp && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      in_x     = 23'($urandom);
      in_y     = 23'($urandom);
      in_first = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    in_first = first;
    in_last  = last;
    in_cin   = cin;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk); #1;
      if (in_ready) begin
        sb.push_back(e);
        acc  = cyc;
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, required acceptance");
    end
  endtask

  // Reference: the whole operation as one wide integer sum, sliced into limbs.
  task automatic send_op(input int n, input bit complete, input logic first0, input logic cin);
    logic [191:0] wx, wy, ws;
    exp_t         e;
    int           a;
    wx = '0;
    wy = '0;
    for (int k = 0; k < n; k++) begin
      wx[23*k +: 23] = opx[k];
      wy[23*k +: 23] = opy[k];
    end
    ws = wx + wy + {191'b0, cin};
    for (int k = 0; k < n; k++) begin
      e.sum  = ws[23*k +: 23];
      e.last = complete && (k == n - 1);
      e.cout = e.last ? ws[23*n] : 1'b0;
      e.idx  = IDX_W'(k);
      send_limb(opx[k], opy[k], (k == 0) ? first0 : 1'b0, e.last, cin, e, a);
      acc_c[k] = a;
    end
    prev_open = !complete;
  endtask

  task automatic drain();
    for (int t = 0; t < 2000 && sb.size() != 0; t++) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: got %0d pending limbs, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [22:0] hold_sum;
    int          n;
    bit          abort;
    logic        f0;
    logic        c;

    @(negedge clk);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out_sum", {9'b0, out_sum}, 32'd0);
    check("reset_out_last_cout_idx", {28'b0, out_last, out_cout, out_idx}, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single limb with carry out.
    opx[0] = 23'h7FFFFF; opy[0] = 23'h000001;
    send_op(1, 1, 1'b1, 1'b0);

    // Three limbs back-to-back.
    opx[0] = 23'h7FFFFF; opx[1] = 23'h7FFFFF; opx[2] = 23'h000000;
    opy[0] = 23'h000001; opy[1] = 23'h000000; opy[2] = 23'h000000;
    send_op(3, 1, 1'b1, 1'b0);
    check("three_limb_no_bubble", 32'(acc_c[2] - acc_c[0]), 32'd2);

    // Abort: open an operation with carry 1, then restart.
    opx[0] = 23'h7FFFFF; opy[0] = 23'h000001;
    send_op(1, 0, 1'b1, 1'b0);
    opx[0] = 23'h000001; opy[0] = 23'h000001;
    send_op(1, 1, 1'b1, 1'b0);

    // Wrap of the 2-bit index over 6 limbs.
    for (int k = 0; k < 6; k++) begin
      opx[k] = 23'($urandom);
      opy[k] = 23'($urandom);
    end
    send_op(6, 1, 1'b1, 1'b0);

`ifdef KSA_LIMB_CIN_EN
    opx[0] = 23'h000005; opy[0] = 23'h7FFFFC;
    send_op(1, 1, 1'b1, 1'b1);
`endif
    drain();

    // Backpressure: output held for 3 cycles, then pop and accept together.
    stall_req = 1'b1;
    opx[0] = 23'h123456; opy[0] = 23'h000111;
    send_op(1, 1, 1'b1, 1'b0);
    @(negedge clk); #1;
    hold_sum = out_sum;
    check("stall_hold_value", {9'b0, hold_sum}, 32'h123567);
    for (int t = 0; t < 3; t++) begin
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      check("stall_out_valid", {31'b0, out_valid}, 32'd1);
      check("stall_out_sum", {9'b0, out_sum}, {9'b0, hold_sum});
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    stall_req = 1'b0;
    in_valid = 1'b1;
    @(negedge clk); #1;
    check("pop_push_same_cycle", {29'b0, out_valid, out_ready, in_ready}, 32'd7);
    in_valid = 1'b0;
    @(posedge clk); #1;
    opx[0] = 23'h000010; opy[0] = 23'h000020;
    send_op(1, 1, 1'b1, 1'b0);
    drain();

    // Reset mid-operation with an output pending and carry_q=1.
    stall_req = 1'b1;
    opx[0] = 23'h7FFFFF; opy[0] = 23'h000001;
    send_op(1, 0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_out_fields", {out_sum, out_last, out_cout, out_idx}, 32'd0);
    check("arst_in_ready", {31'b0, in_ready}, 32'd1);
    sb.delete();
    prev_open = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    stall_req = 1'b0;
    @(posedge clk); #1;
    opx[0] = 23'h000001; opy[0] = 23'h000001;
    send_op(1, 1, 1'b0, 1'b0);
    drain();

    // Randomized operations with gaps, backpressure, aborts and unframed starts.
    rand_bp = 1'b1;
    for (int op = 0; op < 150; op++) begin
      n     = $urandom_range(1, 8);
      abort = ($urandom_range(0, 5) == 0);
      f0    = prev_open ? 1'b1 : 1'($urandom_range(0, 1));
`ifdef KSA_LIMB_CIN_EN
      c = 1'($urandom);
`else
      c = 1'b0;
`endif
      for (int k = 0; k < n; k++) begin
        opx[k] = ($urandom_range(0, 3) == 0) ? 23'h7FFFFF : 23'($urandom);
        opy[k] = ($urandom_range(0, 3) == 0) ? 23'h000000 : 23'($urandom);
      end
      send_op(n, !abort, f0, c);
    end
    rand_bp = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish before 500us");
    $fatal(1);
  end

endmodule
